// File: rtl/beam_alignment_l1.sv
// beam_alignment_l1: L1 delay-and-sum beamformer with one power-threshold trigger per beam.
// Pipeline: sample history -> aligned sums -> squares -> window power -> registered compare.
module beam_alignment_l1 #(
  parameter int                         NBEAMS      = 8,
  parameter int                         NCHAN       = 8,
  parameter int                         NSAMP       = 8,
  parameter int                         NBITS       = 5,
  parameter int                         MAX_DELAY   = 31,
  parameter logic [NBEAMS*NCHAN*6-1:0]  BEAM_DELAYS = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NSAMP*NBITS-1:0]   data_i [NCHAN],
  input  logic [17:0]              thresh_i,
  input  logic [NBEAMS-1:0]        thresh_ce_i,
  input  logic                     update_i,
  output logic [NBEAMS-1:0]        trigger_o
);

  localparam int ABITS = 8;
  localparam int SQBITS = 2 * ABITS;
  localparam int PBITS = 18;
  localparam int HIST = (MAX_DELAY + NSAMP - 1) / NSAMP + 1;
  localparam int DEPTH = HIST * NSAMP;

  // Newest-first history: tap m of channel j holds x_j[NSAMP*t + NSAMP-1 - m].
  logic signed [NBITS-1:0] hist_reg [NCHAN][DEPTH];

  function automatic logic signed [NBITS-1:0] to_signed(input logic [NBITS-1:0] raw);
    return {~raw[NBITS-1], raw[NBITS-2:0]};
  endfunction

  function automatic int delay_of(input int b, input int j);
    int d;
    d = int'(BEAM_DELAYS[(b*NCHAN+j)*6 +: 6]);
    if (d > MAX_DELAY) d = MAX_DELAY;
    return d;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NCHAN; j++)
        for (int m = 0; m < DEPTH; m++)
          hist_reg[j][m] <= '0;
    end else begin
      for (int j = 0; j < NCHAN; j++) begin
        for (int m = 0; m < NSAMP; m++)
          hist_reg[j][m] <= to_signed(data_i[j][(NSAMP-1-m)*NBITS +: NBITS]);
        for (int m = NSAMP; m < DEPTH; m++)
          hist_reg[j][m] <= hist_reg[j][m-NSAMP];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBEAMS; gi++) begin : g_beam
      logic signed [ABITS-1:0]  align_next [NSAMP];
      logic signed [ABITS-1:0]  align_reg  [NSAMP];
      logic        [SQBITS-1:0] sq_next    [NSAMP];
      logic        [SQBITS-1:0] sq_reg     [NSAMP];
      logic        [PBITS-1:0]  power_next;
      logic        [PBITS-1:0]  power_reg;
      logic        [PBITS-1:0]  pending_reg;
      logic        [PBITS-1:0]  active_reg;
      logic                     trigger_reg;

      // Eight signed 5-bit terms span -128..120, so the 8-bit sum never wraps.
      always_comb begin
        for (int k = 0; k < NSAMP; k++) begin
          align_next[k] = '0;
          for (int j = 0; j < NCHAN; j++)
            align_next[k] = align_next[k]
                          + ABITS'(hist_reg[j][NSAMP-1-k+delay_of(gi, j)]);
        end
      end

      always_comb begin
        for (int k = 0; k < NSAMP; k++)
          sq_next[k] = SQBITS'(align_reg[k]) * SQBITS'(align_reg[k]);
      end

      always_comb begin
        power_next = '0;
        for (int k = 0; k < NSAMP; k++)
          power_next = power_next + PBITS'(sq_reg[k]);
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int k = 0; k < NSAMP; k++) begin
            align_reg[k] <= '0;
            sq_reg[k]    <= '0;
          end
          power_reg   <= '0;
          pending_reg <= '1;
          active_reg  <= '1;
          trigger_reg <= 1'b0;
        end else begin
          for (int k = 0; k < NSAMP; k++) begin
            align_reg[k] <= align_next[k];
            sq_reg[k]    <= sq_next[k];
          end
          power_reg <= power_next;
          if (thresh_ce_i[gi])
            pending_reg <= thresh_i;
          // Same-edge ce and update: active takes the pending value from before this edge.
          if (update_i)
            active_reg <= pending_reg;
          trigger_reg <= (power_reg > active_reg);
        end
      end

      assign trigger_o[gi] = trigger_reg;
    end
  endgenerate

endmodule

// File: tb/tb_beam_alignment_l1.sv
// Randomised bench for beam_alignment_l1 against a stream-level delay-and-sum power model.
module tb_beam_alignment_l1;

  localparam int NB = 8;
  localparam int NC = 8;
  localparam int NS = 8;
  localparam int MAXE = 1024;

  function automatic int dly(input int b, input int j);
    return (b * 7 + j * 5 + b * j) % 32;
  endfunction

  function automatic logic [NB*NC*6-1:0] make_delays();
    logic [NB*NC*6-1:0] v;
    v = '0;
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < NC; j++)
        v[(b*NC+j)*6 +: 6] = 6'(dly(b, j));
    return v;
  endfunction

  localparam logic [NB*NC*6-1:0] DELAYS = make_delays();

  logic          clk = 1'b0;
  logic          rst_n;
  logic [39:0]   data [NC];
  logic [17:0]   thresh;
  logic [NB-1:0] ce;
  logic          update;
  logic [NB-1:0] trigger;

  always #5 clk = ~clk;

  beam_alignment_l1 #(
    .NBEAMS(NB), .NCHAN(NC), .NSAMP(NS), .NBITS(5), .MAX_DELAY(31), .BEAM_DELAYS(DELAYS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .thresh_i(thresh),
    .thresh_ce_i(ce), .update_i(update), .trigger_o(trigger)
  );

  int    vectors = 0;
  int    miscompares = 0;
  int    cur [NC][NS];
  int    xs [NC][MAXE*NS];
  int    pend [NB];
  int    act [NB];
  int    edge_n;
  int    pulse_n0;
  string phase;

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int xs_at(input int j, input int n);
    return (n < 0) ? 0 : xs[j][n];
  endfunction

  function automatic int power_of(input int b, input int t);
    int p;
    int a;
    p = 0;
    if (t < 0) return 0;
    for (int k = 0; k < NS; k++) begin
      a = 0;
      for (int j = 0; j < NC; j++)
        a += xs_at(j, NS * t + k - dly(b, j));
      p += a * a;
    end
    return p;
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int b = 0; b < NB; b++) begin
      pend[b] = 'h3FFFF;
      act[b]  = 'h3FFFF;
    end
  endtask

  task automatic step();
    int exp_v;
    for (int j = 0; j < NC; j++)
      for (int k = 0; k < NS; k++)
        data[j][5*k +: 5] = 5'(cur[j][k]);
    @(posedge clk);
    #1;
    if (edge_n >= MAXE) begin
      $display("FAIL model_overflow: observed %0d expected below %0d", edge_n, MAXE);
      $fatal(1);
    end
    for (int j = 0; j < NC; j++)
      for (int k = 0; k < NS; k++)
        xs[j][NS*edge_n+k] = cur[j][k] - 16;
    exp_v = 0;
    for (int b = 0; b < NB; b++)
      if (power_of(b, edge_n - 4) > act[b]) exp_v |= (1 << b);
    check(phase, int'(trigger), exp_v);
    $display("edge %0d %s ce=%02h upd=%0d th=%0d trigger=%02h expected=%02h",
             edge_n, phase, ce, update, thresh, trigger, exp_v);
    for (int b = 0; b < NB; b++)
      if (update) act[b] = pend[b];
    for (int b = 0; b < NB; b++)
      if (ce[b]) pend[b] = int'(thresh);
    edge_n++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic fill(input int v);
    for (int j = 0; j < NC; j++)
      for (int k = 0; k < NS; k++)
        cur[j][k] = v;
  endtask

  task automatic load_all(input int th);
    thresh = 18'(th);
    ce = '1;
    update = 1'b0;
    step();
    ce = '0;
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  function automatic int noise();
    return $urandom_range(0, 7) + $urandom_range(0, 8) + $urandom_range(0, 8) + $urandom_range(0, 7);
  endfunction

  initial begin
    rst_n = 1'b0;
    thresh = '0;
    ce = '0;
    update = 1'b0;
    fill(16);
    for (int j = 0; j < NC; j++) data[j] = {8{5'd16}};
    model_reset();
    pulse_n0 = -1000;
    #12;
    check("reset_state", int'(trigger), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero signal with thresholds 9000
    phase = "idle16";
    run(4);
    load_all(9000);
    run(8);

    // Pending-only load, then update; then ce and update on the same edge
    phase = "pending";
    for (int k = 0; k < NS; k++) cur[0][k] = 20;
    run(6);
    thresh = 18'd100;
    ce = 8'h02;
    step();
    ce = '0;
    run(8);
    update = 1'b1;
    step();
    update = 1'b0;
    run(4);
    thresh = 18'd200;
    ce = 8'h02;
    update = 1'b1;
    step();
    ce = '0;
    update = 1'b0;
    run(3);
    thresh = 18'd127;
    ce = 8'h0C;
    step();
    ce = '0;
    update = 1'b1;
    step();
    update = 1'b0;
    run(4);

    // Full-scale input
    phase = "full_scale";
    load_all(9000);
    fill(31);
    run(12);

    // Strict compare boundary at P=8
    phase = "boundary";
    fill(16);
    for (int k = 0; k < NS; k++) cur[0][k] = 17;
    load_all(8);
    run(10);
    load_all(7);
    run(8);

    // Noise with periodic beam-0-aligned bipolar pulses
    phase = "noise_pulse";
    load_all(9000);
    for (int e = 0; e < 300; e++) begin
      if (e % 60 == 20) pulse_n0 = NS * edge_n + 40;
      for (int j = 0; j < NC; j++)
        for (int k = 0; k < NS; k++) begin
          int v;
          int i;
          v = noise();
          i = NS * edge_n + k - pulse_n0 + dly(0, j);
          if (i >= 0 && i < 11) v += (i % 2 == 0) ? 8 : -8;
          if (v < 0) v = 0;
          if (v > 31) v = 31;
          cur[j][k] = v;
        end
      step();
    end

    // Random data with random threshold traffic
    phase = "random_thresh";
    for (int e = 0; e < 200; e++) begin
      for (int j = 0; j < NC; j++)
        for (int k = 0; k < NS; k++)
          cur[j][k] = $urandom_range(0, 31);
      thresh = 18'($urandom_range(2000, 12000));
      ce = 8'($urandom);
      update = ($urandom_range(0, 3) == 0);
      step();
    end
    ce = '0;
    update = 1'b0;

    // Reset in the middle of an active stream
    phase = "pre_reset";
    load_all(9000);
    fill(31);
    run(8);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", int'(trigger), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    phase = "post_reset";
    run(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
